syn_fifo_flags: RTL and testbench

- Parametrised synchronous FIFO; the successor to the team's basic single-clock FIFO.
- Adds a programmable occupancy count, almost-full/almost-empty thresholds, a synchronous flush, a read-data valid strobe, and sticky overflow/underflow error flags with clear.
- Used as the elastic buffer between the SHA3 input loader and the absorb datapath, where word width and depth vary per instance.

---
 rtl/syn_fifo_flags.sv | 121 ++++++++++++
 tb/tb_syn_fifo_flags.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/syn_fifo_flags.sv
// ============================================================================
// Module      : syn_fifo_flags
// Description : Single-clock FIFO with level, almost thresholds, flush, read
//               valid strobe and sticky overflow/underflow flags.
//               Define SYN_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] w_data,
    input  logic             w_request,
    input  logic             r_request,
    input  logic             clr_err,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    output logic             full_status,
    output logic             empty_status,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LW-1:0] c_full_lvl = LW'(DEPTH);
    localparam logic [LW-1:0] c_af_lvl   = LW'(AF_THRESH);
    localparam logic [LW-1:0] c_ae_lvl   = LW'(AE_THRESH);
    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    logic             w_active;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [PW-1:0]    w_wptr_nxt;
    logic [PW-1:0]    w_rptr_nxt;

    // Status is decoded only from the registered level, never from requests.
    assign full_status  = (r_level == c_full_lvl);
    assign empty_status = (r_level == '0);
    assign almost_full  = (r_level >= c_af_lvl);
    assign almost_empty = (r_level <= c_ae_lvl);
    assign level        = r_level;

    // Flush and reset suppress acceptance so they raise no errors either.
    assign w_active  = rst_n & ~flush;
    assign w_rd_ok   = w_active & r_request & ~empty_status;
    assign w_wr_ok   = w_active & w_request & (~full_status | w_rd_ok);
    assign w_ovf_evt = w_active & w_request & ~w_wr_ok;
    assign w_udf_evt = w_active & r_request & ~w_rd_ok;

    assign w_wptr_nxt = (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_rd_ok) begin
                r_rptr <= w_rptr_nxt;
            end
            r_level   <= r_level + LW'(w_wr_ok) - LW'(w_rd_ok);
            overflow  <= w_ovf_evt | (overflow & ~clr_err);
            underflow <= w_udf_evt | (underflow & ~clr_err);
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    assign r_data  = empty_status ? '0 : r_mem[r_rptr];
    assign r_valid = ~empty_status;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_data <= r_mem[r_rptr];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_fifo_flags.sv
// ============================================================================
// Module      : tb_syn_fifo_flags
// Description : Scoreboard bench for syn_fifo_flags (WIDTH=8, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syn_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       w_request = 1'b0;
    logic       r_request = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] r_data;
    logic       r_valid;
    logic       full_status;
    logic       empty_status;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] level;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q_mem [$];
    logic [7:0] q_exp [$];
    int         m_level = 0;
    logic       m_rv    = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_udf   = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    syn_fifo_flags #(
        .WIDTH     (8),
        .DEPTH     (4),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .w_data       (w_data),
        .w_request    (w_request),
        .r_request    (r_request),
        .clr_err      (clr_err),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full_status  (full_status),
        .empty_status (empty_status),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, step past the edge.
    task automatic drive_cycle(input logic wr, input logic [7:0] wd,
                               input logic rd, input logic clr, input logic fl);
        logic rd_ok;
        logic wr_ok;
        logic [7:0] v;
        rd_ok = !fl && rd && (m_level != 0);
        wr_ok = !fl && wr && ((m_level != 4) || rd_ok);
        w_request = wr;
        w_data    = wd;
        r_request = rd;
        clr_err   = clr;
        flush     = fl;
        if (fl) begin
            q_mem.delete();
            m_rv = 1'b0;
        end else begin
            if (rd_ok) begin
                v = q_mem.pop_front();
                q_exp.push_back(v);
                m_rdata = v;
            end
            if (wr_ok) q_mem.push_back(wd);
            m_rv  = rd_ok;
            m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
            m_udf = (rd && !rd_ok) || (m_udf && !clr);
        end
        m_level = q_mem.size();
        @(posedge clk);
        #1;
        w_request = 1'b0;
        r_request = 1'b0;
        clr_err   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic model_reset();
        q_mem.delete();
        q_exp.delete();
        m_level = 0;
        m_rv    = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (empty_status !== 1'b1 || full_status !== 1'b0) begin bad++; $display("FAIL reset_empty_full: got %b%b want 10", empty_status, full_status); end
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost: got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_errors: got %b%b want 00", overflow, underflow); end
        total++; if (r_valid !== 1'b0 || r_data !== 8'h00) begin bad++; $display("FAIL reset_read: got v=%b d=%h want v=0 d=00", r_valid, r_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            total++; if (level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level%0d: got %0d want %0d", i, level, i + 1); end
            total++; if (almost_full !== (i >= 2)) begin bad++; $display("FAIL fill_af%0d: got %b want %b", i, almost_full, (i >= 2)); end
            total++; if (full_status !== (i == 3)) begin bad++; $display("FAIL fill_full%0d: got %b want %b", i, full_status, (i == 3)); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf%0d: got %b want 0", i, overflow); end
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (level !== 3'(m_level)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", level, m_level); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_sticky: got %b want %b", overflow, m_ovf); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_clear: got %b want %b", overflow, m_ovf); end
    endtask

    task automatic test_full_rw();
        logic [7:0] e;
        drive_cycle(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fullrw_level: got %0d want 4", level); end
        total++; if (r_valid !== 1'b1) begin bad++; $display("FAIL fullrw_valid: got %b want 1", r_valid); end
        e = q_exp.pop_front();
        total++; if (r_data !== e) begin bad++; $display("FAIL fullrw_data: got %h want %h", r_data, e); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            total++; if (r_valid !== m_rv) begin bad++; $display("FAIL drain_valid%0d: got %b want %b", i, r_valid, m_rv); end
            if (m_rv) begin
                e = q_exp.pop_front();
                total++; if (r_data !== e) begin bad++; $display("FAIL drain_data%0d: got %h want %h", i, r_data, e); end
            end
        end
        total++; if (empty_status !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL drain_empty: got e=%b l=%0d want e=1 l=0", empty_status, level); end
    endtask

    task automatic test_empty_rw();
        logic [7:0] e;
        drive_cycle(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
        total++; if (level !== 3'd1) begin bad++; $display("FAIL emptyrw_level: got %0d want 1", level); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL emptyrw_udf: got %b want 1", underflow); end
        total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL emptyrw_valid: got %b want 0", r_valid); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        total++; if (r_valid !== 1'b1) begin bad++; $display("FAIL emptyrd_valid: got %b want 1", r_valid); end
        e = q_exp.pop_front();
        total++; if (r_data !== e) begin bad++; $display("FAIL emptyrd_data: got %h want %h", r_data, e); end
        total++; if (empty_status !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL emptyrd_flags: got e=%b ae=%b want 1 1", empty_status, almost_empty); end
        total++; if (underflow !== m_udf) begin bad++; $display("FAIL emptyrd_udfclr: got %b want %b", underflow, m_udf); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) drive_cycle(1'b1, 8'h20 + 8'(i / 2), 1'b0, 1'b0, 1'b0);
            else            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            total++; if (level !== 3'(m_level) || level > 3'd4) begin bad++; $display("FAIL wrap_level%0d: got %0d want %0d", i, level, m_level); end
            if (m_rv) begin
                e = q_exp.pop_front();
                total++; if (r_valid !== 1'b1 || r_data !== e) begin bad++; $display("FAIL wrap_data%0d: got v=%b d=%h want v=1 d=%h", i, r_valid, r_data, e); end
            end
        end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL wrap_errors: got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        total++; if (level !== 3'd3) begin bad++; $display("FAIL preflush_level: got %0d want 3", level); end
        drive_cycle(1'b1, 8'h50, 1'b0, 1'b0, 1'b1);
        total++; if (level !== 3'd0 || empty_status !== 1'b1) begin bad++; $display("FAIL flush_level: got l=%0d e=%b want l=0 e=1", level, empty_status); end
        total++; if (overflow !== m_ovf || underflow !== m_udf) begin bad++; $display("FAIL flush_errors: got %b%b want %b%b", overflow, underflow, m_ovf, m_udf); end
        total++; if (r_valid !== 1'b0 || r_data !== m_rdata) begin bad++; $display("FAIL flush_read: got v=%b d=%h want v=0 d=%h", r_valid, r_data, m_rdata); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1 || r_valid !== 1'b1) begin bad++; $display("FAIL premrst_state: got ovf=%b v=%b want 1 1", overflow, r_valid); end
        rst_n     = 1'b0;
        w_request = 1'b1;
        r_request = 1'b1;
        w_data    = 8'h77;
        @(posedge clk);
        #1;
        model_reset();
        total++; if (level !== 3'd0 || empty_status !== 1'b1 || full_status !== 1'b0) begin bad++; $display("FAIL mrst_level: got l=%0d e=%b f=%b want 0 1 0", level, empty_status, full_status); end
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL mrst_almost: got ae=%b af=%b want 1 0", almost_empty, almost_full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL mrst_errors: got %b%b want 00", overflow, underflow); end
        total++; if (r_valid !== 1'b0 || r_data !== 8'h00) begin bad++; $display("FAIL mrst_read: got v=%b d=%h want 0 00", r_valid, r_data); end
        w_request = 1'b0;
        r_request = 1'b0;
        rst_n     = 1'b1;
        drive_cycle(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (r_valid !== 1'b1 || r_data !== 8'h88) begin bad++; $display("FAIL postrst_read: got v=%b d=%h want 1 88", r_valid, r_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_flush();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
